and_gate: RTL and testbench
===========================

// Module: and_gate
// PURPOSE
//   Branch-decision gate of the single-cycle MIPS datapath: ANDs the control unit's Branch
//   signal with the ALU Zero flag to produce PCSrc (take-branch select for the PC mux).
//   Main output is purely combinational, so branches resolve in the same cycle.
//   Also holds a registered copy of the decision and saturating branch statistics for debug/perf.
// PARAMETERS
//   CNT_W  32  width of the statistics counters (>=2)
// PORTS
//   clk         input   1      single system clock; all registers update on rising edge
//   rst_n       input   1      synchronous, active-low reset
//   inpBranch   input   1      Branch control from the control unit
//   inpZero     input   1      Zero flag from the ALU
//   cntEn       input   1      1 = statistics counters may update this cycle
//   andOut      output  1      PCSrc = inpBranch & inpZero (combinational)
//   andOutQ     output  1      andOut registered one cycle
//   branchCnt   output  CNT_W  count of cycles with inpBranch=1 while cntEn=1
//   takenCnt    output  CNT_W  count of cycles with andOut=1 while cntEn=1
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-low (rst_n), sampled only on posedge clk.
//   - andOut = inpBranch & inpZero; zero latency; independent of clk, rst_n, cntEn.
//     Valid with clk idle and rst_n never asserted (pure combinational use).
//   - Truth table for {inpZero,inpBranch}: 00->0, 01->0, 10->0, 11->1.
//   - X/Z on an input may propagate to andOut; no masking.
//   - Reset (rst_n=0 at posedge): andOutQ=0, branchCnt=0, takenCnt=0. Reset wins over all
//     other updates in the same cycle; andOut keeps following its inputs during reset.
//   - Each posedge with rst_n=1: andOutQ <= andOut.
//   - Each posedge with rst_n=1 and cntEn=1:
//       branchCnt += inpBranch; takenCnt += andOut.
//     Both counters saturate at 2**CNT_W-1 and hold there; no wrap to 0.
//   - cntEn=0: counters hold; andOutQ still updates.
//   - Invariant: takenCnt <= branchCnt at all times.
//   - No state machine; no handshake.
// STRUCTURE
//   - Shared package cpu_pkg: typedef logic [CNT_W-1:0] stat_cnt_t; localparam
//     PCSRC_SEQ=1'b0, PCSRC_BRANCH=1'b1 for the PC-mux select encoding.
//   - One natural sub-module: sat_counter (CNT_W param; inputs clk, rst_n, inc; output count).
//     Instantiate twice, for branchCnt and takenCnt.
//   - Gate, output register and counter instances live in and_gate; no other hierarchy.
// TESTING
//   1. clk held low, rst_n=1; apply {inpZero,inpBranch}=00,01,10,11, 10 ns apart
//      -> andOut=0,0,0,1 sampled 10 ns after each change; 0 mismatches.
//   2. rst_n=0 for 2 cycles with inputs=11 -> andOutQ=0, both counters=0; andOut=1 throughout.
//   3. rst_n=1, cntEn=1; 4 cycles of {Zero,Branch}=11,01,10,11
//      -> branchCnt=3, takenCnt=2; andOutQ lags andOut by one cycle (1,0,0,1).
//   4. cntEn=0, 3 cycles of inputs=11 -> counters unchanged; andOutQ=1.
//   5. CNT_W=2, cntEn=1, inputs=11 for 5 cycles -> both counters saturate at 3 and hold.
//   6. rst_n=0 for one cycle mid-count with inputs=11 -> counters=0 the next cycle;
//      counting resumes at 1 after rst_n returns to 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath definitions: statistics counter type and PC-mux select encoding.
package cpu_pkg;

  localparam int unsigned STAT_CNT_W = 32;

  typedef logic [STAT_CNT_W-1:0] stat_cnt_t;

  localparam logic PCSRC_SEQ    = 1'b0;
  localparam logic PCSRC_BRANCH = 1'b1;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/and_gate.sv
// Branch-decision gate (PCSrc = Branch & Zero) with a registered copy and branch statistics.
module and_gate
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = STAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inpBranch,
  input  logic             inpZero,
  input  logic             cntEn,
  output logic             andOut,
  output logic             andOutQ,
  output logic [CNT_W-1:0] branchCnt,
  output logic [CNT_W-1:0] takenCnt
);

  logic and_q;
  logic and_d;
  logic branch_inc;
  logic taken_inc;

  // Same-cycle branch resolution; X on either input is allowed to propagate.
  assign andOut = inpBranch & inpZero;

  always_comb begin
    and_d      = andOut;
    branch_inc = cntEn & inpBranch;
    taken_inc  = cntEn & andOut;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and_q <= PCSRC_SEQ;
    end else begin
      and_q <= and_d;
    end
  end

  assign andOutQ = and_q;

  // Taken implies branch, so takenCnt can never overtake branchCnt.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_inc),
    .count (branchCnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken_inc),
    .count (takenCnt)
  );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: 32-bit instance plus a 2-bit instance for saturation.
module tb_and_gate;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic        inpBranch;
  logic        inpZero;
  logic        cntEn;

  logic        and_out;
  logic        and_out_q;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;

  logic        and_out_s;
  logic        and_out_q_s;
  logic [1:0]  branch_cnt_s;
  logic [1:0]  taken_cnt_s;

  typedef struct packed {
    logic        a;
    logic        q;
    logic [31:0] bc;
    logic [31:0] tc;
    logic [1:0]  bc2;
    logic [1:0]  tc2;
  } obs_t;

  obs_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_q;
  logic [31:0] m_bc;
  logic [31:0] m_tc;
  logic [1:0]  m_bc2;
  logic [1:0]  m_tc2;

  and_gate #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inpBranch (inpBranch),
    .inpZero   (inpZero),
    .cntEn     (cntEn),
    .andOut    (and_out),
    .andOutQ   (and_out_q),
    .branchCnt (branch_cnt),
    .takenCnt  (taken_cnt)
  );

  and_gate #(.CNT_W(2)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .inpBranch (inpBranch),
    .inpZero   (inpZero),
    .cntEn     (cntEn),
    .andOut    (and_out_s),
    .andOutQ   (and_out_q_s),
    .branchCnt (branch_cnt_s),
    .takenCnt  (taken_cnt_s)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.a   = and_out;
    o.q   = and_out_q;
    o.bc  = branch_cnt;
    o.tc  = taken_cnt;
    o.bc2 = branch_cnt_s;
    o.tc2 = taken_cnt_s;
    return o;
  endfunction

  // Drive one cycle at negedge, push the model's post-edge expectation, then wait past posedge.
  task automatic drive_cycle(input logic r, input logic en, input logic z, input logic b);
    obs_t e;
    @(negedge clk);
    rst_n     = r;
    cntEn     = en;
    inpZero   = z;
    inpBranch = b;
    if (!r) begin
      m_q = 1'b0; m_bc = '0; m_tc = '0; m_bc2 = '0; m_tc2 = '0;
    end else begin
      m_q = z & b;
      if (en) begin
        if (b && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
        if (z && b && m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 32'd1;
        if (b && m_bc2 != 2'd3) m_bc2 = m_bc2 + 2'd1;
        if (z && b && m_tc2 != 2'd3) m_tc2 = m_tc2 + 2'd1;
      end
    end
    e.a = z & b; e.q = m_q; e.bc = m_bc; e.tc = m_tc; e.bc2 = m_bc2; e.tc2 = m_tc2;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    logic [1:0] pat;
    logic       exp;
    clk_run = 1'b0;
    rst_n   = 1'b1;
    cntEn   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      {inpZero, inpBranch} = pat;
      exp = (pat == 2'b11);
      #10;
      total++;
      if (and_out !== exp || and_out_s !== exp) begin
        bad++;
        $display("FAIL comb_%b: andOut=%b/%b expected %b", pat, and_out, and_out_s, exp);
      end
    end
  endtask

  task automatic test_reset();
    obs_t e, g;
    clk_run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset_%0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_count();
    logic [1:0] pats [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
    obs_t e, g;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, pats[i][1], pats[i][0]);
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e || g.tc > g.bc) begin
        bad++;
        $display("FAIL count_%0d: got %h expected %h", i, g, e);
      end
    end
    total++;
    if (branch_cnt !== 32'd3 || taken_cnt !== 32'd2) begin
      bad++;
      $display("FAIL count_final: branch=%0d taken=%0d expected 3 2", branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_hold();
    obs_t e, g;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e || g.q !== 1'b1) begin
        bad++;
        $display("FAIL hold_%0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, g;
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    g = observe(); e = sb.pop_front(); total++;
    if (g !== e) begin
      bad++;
      $display("FAIL sat_reset: got %h expected %h", g, e);
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL sat_%0d: got %h expected %h", i, g, e);
      end
    end
    total++;
    if (branch_cnt_s !== 2'd3 || taken_cnt_s !== 2'd3) begin
      bad++;
      $display("FAIL sat_final: branch=%0d taken=%0d expected 3 3", branch_cnt_s, taken_cnt_s);
    end
  endtask

  task automatic test_mid_reset();
    logic r_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    obs_t e, g;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(r_seq[i], 1'b1, 1'b1, 1'b1);
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL midrst_%0d: got %h expected %h", i, g, e);
      end
    end
    total++;
    if (branch_cnt !== 32'd2 || taken_cnt !== 32'd2) begin
      bad++;
      $display("FAIL midrst_final: branch=%0d taken=%0d expected 2 2", branch_cnt, taken_cnt);
    end
  endtask

  initial begin
    clk_run   = 1'b0;
    rst_n     = 1'b1;
    cntEn     = 1'b0;
    inpBranch = 1'b0;
    inpZero   = 1'b0;
    m_q = 1'b0; m_bc = '0; m_tc = '0; m_bc2 = '0; m_tc2 = '0;
    test_comb();
    test_reset();
    test_count();
    test_hold();
    test_saturate();
    test_mid_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_and_gate
